// File: rtl/rst_sequencer.sv
// Central reset sequencer.
// The board reset asserts every downstream reset immediately. Its release is
// synchronised, then the downstream domains are let go one at a time, lowest
// index first, with a fixed gap between them. A level soft-reset request with
// a 4-phase handshake re-runs the staged release without a board reset.
module rst_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int STAGE_DLY   = 8,
    parameter int SYNC_STAGES = 2,
    parameter int SOFT_HOLD   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  soft_rst_req_i,
    output logic                  soft_rst_ack_o,
    output logic [NUM_STAGES-1:0] rst_n_o,
    output logic                  rst_done_o
);

    // The counter times both the inter-stage gap and the soft-reset hold.
    localparam int CNT_SPAN = (STAGE_DLY > SOFT_HOLD) ?
                              ((STAGE_DLY > 2) ? STAGE_DLY : 2) :
                              ((SOFT_HOLD > 2) ? SOFT_HOLD : 2);
    localparam int CW = $clog2(CNT_SPAN);
    localparam int IW = $clog2((NUM_STAGES > 2) ? NUM_STAGES : 2);

    localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_DLY - 1);
    localparam logic [CW-1:0] SOFT_LAST  = CW'(SOFT_HOLD - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_RELEASE,
        ST_DONE,
        ST_SOFT
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_ok;
    logic                   sync_ok_next;

    // The chain only ever fills with ones, so sync_ok turns 1 on the edge
    // where the next-to-last flop is already 1; leave SYNC on that edge.
    assign sync_ok      = sync_q[SYNC_STAGES-1];
    assign sync_ok_next = sync_q[SYNC_STAGES-2] | sync_ok;

    // Release synchroniser: cleared asynchronously, fills with ones afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Sequencing FSM; every output is a flop written only here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_SYNC;
            cnt            <= '0;
            idx            <= '0;
            rst_n_o        <= '0;
            rst_done_o     <= 1'b0;
            soft_rst_ack_o <= 1'b0;
        end else begin
            case (state)
                ST_SYNC: begin
                    if (sync_ok_next) begin
                        state <= ST_RELEASE;
                        cnt   <= '0;
                        idx   <= '0;
                    end
                end

                ST_RELEASE: begin
                    if (cnt == STAGE_LAST) begin
                        cnt <= '0;
                        idx <= idx + 1'b1;
                        for (int k = 0; k < NUM_STAGES; k++) begin
                            if (idx == IW'(k)) begin
                                rst_n_o[k] <= 1'b1;
                            end
                        end
                        if (idx == IDX_LAST) begin
                            state      <= ST_DONE;
                            rst_done_o <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    if (soft_rst_req_i) begin
                        state          <= ST_SOFT;
                        rst_n_o        <= '0;
                        rst_done_o     <= 1'b0;
                        soft_rst_ack_o <= 1'b1;
                        cnt            <= '0;
                    end
                end

                ST_SOFT: begin
                    if (cnt == SOFT_LAST) begin
                        if (!soft_rst_req_i) begin
                            state          <= ST_RELEASE;
                            cnt            <= '0;
                            idx            <= '0;
                            soft_rst_ack_o <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_SYNC;
                    cnt   <= '0;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_sequencer.sv
// Testbench for rst_sequencer: directed scenarios plus a randomized soft-reset
// requester, compared against an edge-count based model of the release timing.
module tb_rst_sequencer;

    localparam int NUM_STAGES  = 4;
    localparam int STAGE_DLY   = 8;
    localparam int SYNC_STAGES = 2;
    localparam int SOFT_HOLD   = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       soft_rst_req_i;
    logic       soft_rst_ack_o;
    logic [3:0] rst_n_o;
    logic       rst_done_o;

    logic       req2 = 1'b0;
    logic       ack2;
    logic [1:0] rst_n2;
    logic       done2;

    int test_cnt = 0;
    int fail_cnt = 0;
    int edge_no  = 0;

    // Model state: either in a soft hold or counting a staged release from m_base.
    bit m_soft;
    bit m_done;
    bit m_ack;
    int m_base;
    int m_soft_start;
    int m_rel;

    int s_edge;
    int gap;
    int hold;
    int guard;

    rst_sequencer #(
        .NUM_STAGES (NUM_STAGES),
        .STAGE_DLY  (STAGE_DLY),
        .SYNC_STAGES(SYNC_STAGES),
        .SOFT_HOLD  (SOFT_HOLD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .soft_rst_req_i(soft_rst_req_i),
        .soft_rst_ack_o(soft_rst_ack_o),
        .rst_n_o       (rst_n_o),
        .rst_done_o    (rst_done_o)
    );

    rst_sequencer #(
        .NUM_STAGES (2),
        .STAGE_DLY  (1),
        .SYNC_STAGES(SYNC_STAGES),
        .SOFT_HOLD  (SOFT_HOLD)
    ) dut_corner (
        .clk           (clk),
        .reset         (reset),
        .soft_rst_req_i(req2),
        .soft_rst_ack_o(ack2),
        .rst_n_o       (rst_n2),
        .rst_done_o    (done2)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    function automatic int released(int elapsed, int n, int dly);
        if (elapsed < 0) return 0;
        return (elapsed / dly > n) ? n : elapsed / dly;
    endfunction

    function automatic logic [31:0] mask(int k);
        return (32'(1) << k) - 32'(1);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s at edge %0d: observed %0h expected %0h", tag, edge_no, obs, exp);
        end
    endtask

    task automatic checkZeros(input string tag);
        checkOutput({tag, "_rst_n"}, 32'(rst_n_o), 32'(0));
        checkOutput({tag, "_done"}, 32'(rst_done_o), 32'(0));
        checkOutput({tag, "_ack"}, 32'(soft_rst_ack_o), 32'(0));
        checkOutput({tag, "_rst_n_p2"}, 32'(rst_n2), 32'(0));
        checkOutput({tag, "_done_p2"}, 32'(done2), 32'(0));
    endtask

    task automatic modelReset();
        m_soft  = 1'b0;
        m_done  = 1'b0;
        m_ack   = 1'b0;
        m_rel   = 0;
        m_base  = SYNC_STAGES;
        edge_no = 0;
    endtask

    task automatic modelEdge(input logic req);
        if (m_soft) begin
            if ((edge_no - m_soft_start >= SOFT_HOLD) && !req) begin
                m_soft = 1'b0;
                m_ack  = 1'b0;
                m_base = edge_no;
            end
        end else if (m_done && req) begin
            m_soft       = 1'b1;
            m_ack        = 1'b1;
            m_soft_start = edge_no;
        end
        m_rel  = m_soft ? 0 : released(edge_no - m_base, NUM_STAGES, STAGE_DLY);
        m_done = !m_soft && (m_rel == NUM_STAGES);
    endtask

    task automatic checkModel();
        int r2;
        r2 = released(edge_no - SYNC_STAGES, 2, 1);
        checkOutput("rst_n", 32'(rst_n_o), mask(m_rel));
        checkOutput("done", 32'(rst_done_o), 32'(m_done));
        checkOutput("ack", 32'(soft_rst_ack_o), 32'(m_ack));
        checkOutput("rst_n_p2", 32'(rst_n2), mask(r2));
        checkOutput("done_p2", 32'(done2), 32'(r2 == 2));
        checkOutput("ack_p2", 32'(ack2), 32'(0));
    endtask

    // Drive req for one cycle, sample 1 ns after the edge, advance the model.
    task automatic applyStimulus(input logic req);
        soft_rst_req_i = req;
        @(posedge clk);
        #1;
        edge_no++;
        modelEdge(req);
        checkModel();
    endtask

    task automatic runTo(input int target, input logic req);
        for (int i = 0; i < 1000 && edge_no < target; i++) begin
            applyStimulus(req);
        end
    endtask

    // Assert reset right now, check it acts without a clock, hold, then release.
    task automatic holdReset(input int cycles);
        soft_rst_req_i = 1'b0;
        reset = 1'b0;
        #1;
        checkZeros("async_rst");
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            checkZeros("in_rst");
        end
        @(negedge clk);
        reset = 1'b1;
        modelReset();
    endtask

    task automatic waitDone(input int bound);
        for (int i = 0; i < bound && rst_done_o !== 1'b1; i++) begin
            applyStimulus(1'b0);
        end
        checkOutput("wait_done", 32'(rst_done_o), 32'(1));
    endtask

    initial begin
        soft_rst_req_i = 1'b0;
        reset = 1'b1;
        modelReset();
        #2;

        // Power-on sequence with exact release edges, plus the corner instance.
        holdReset(3);
        runTo(2, 1'b0);
        checkOutput("p2_e2", 32'(rst_n2), 32'h0);
        applyStimulus(1'b0);
        checkOutput("p2_e3", 32'(rst_n2), 32'h1);
        applyStimulus(1'b0);
        checkOutput("p2_e4", 32'(rst_n2), 32'h3);
        checkOutput("p2_done_e4", 32'(done2), 32'(1));
        runTo(9, 1'b0);
        checkOutput("po_e9", 32'(rst_n_o), 32'h0);
        applyStimulus(1'b0);
        checkOutput("po_e10", 32'(rst_n_o), 32'h1);
        runTo(18, 1'b0);
        checkOutput("po_e18", 32'(rst_n_o), 32'h3);
        runTo(26, 1'b0);
        checkOutput("po_e26", 32'(rst_n_o), 32'h7);
        runTo(33, 1'b0);
        checkOutput("po_done_e33", 32'(rst_done_o), 32'(0));
        applyStimulus(1'b0);
        checkOutput("po_e34", 32'(rst_n_o), 32'hF);
        checkOutput("po_done_e34", 32'(rst_done_o), 32'(1));

        // Long soft request held for ten cycles.
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        s_edge = edge_no + 1;
        applyStimulus(1'b1);
        checkOutput("long_ack_s", 32'(soft_rst_ack_o), 32'(1));
        checkOutput("long_rst_s", 32'(rst_n_o), 32'h0);
        runTo(s_edge + 9, 1'b1);
        checkOutput("long_ack_s9", 32'(soft_rst_ack_o), 32'(1));
        applyStimulus(1'b0);
        checkOutput("long_ack_s10", 32'(soft_rst_ack_o), 32'(0));
        runTo(s_edge + 17, 1'b0);
        checkOutput("long_rst_s17", 32'(rst_n_o), 32'h0);
        applyStimulus(1'b0);
        checkOutput("long_rst_s18", 32'(rst_n_o), 32'h1);
        runTo(s_edge + 41, 1'b0);
        checkOutput("long_done_s41", 32'(rst_done_o), 32'(0));
        applyStimulus(1'b0);
        checkOutput("long_done_s42", 32'(rst_done_o), 32'(1));

        // Single-cycle soft request still holds for the full minimum.
        applyStimulus(1'b0);
        s_edge = edge_no + 1;
        applyStimulus(1'b1);
        checkOutput("short_ack_s", 32'(soft_rst_ack_o), 32'(1));
        runTo(s_edge + 3, 1'b0);
        checkOutput("short_ack_s3", 32'(soft_rst_ack_o), 32'(1));
        applyStimulus(1'b0);
        checkOutput("short_ack_s4", 32'(soft_rst_ack_o), 32'(0));
        runTo(s_edge + 11, 1'b0);
        checkOutput("short_rst_s11", 32'(rst_n_o), 32'h0);
        applyStimulus(1'b0);
        checkOutput("short_rst_s12", 32'(rst_n_o), 32'h1);
        runTo(s_edge + 36, 1'b0);
        checkOutput("short_rst_s36", 32'(rst_n_o), 32'hF);
        checkOutput("short_done_s36", 32'(rst_done_o), 32'(1));

        // Randomized 4-phase requester, sometimes raising req mid-release.
        for (int t = 0; t < 8; t++) begin
            gap = $urandom_range(0, 40);
            repeat (gap) applyStimulus(1'b0);
            guard = 0;
            while (soft_rst_ack_o !== 1'b1 && guard < 100) begin
                applyStimulus(1'b1);
                guard++;
            end
            checkOutput("rand_ack_rise", 32'(soft_rst_ack_o), 32'(1));
            hold = $urandom_range(0, 6);
            repeat (hold) applyStimulus(1'b1);
            guard = 0;
            while (soft_rst_ack_o !== 1'b0 && guard < 50) begin
                applyStimulus(1'b0);
                guard++;
            end
            checkOutput("rand_ack_fall", 32'(soft_rst_ack_o), 32'(0));
        end
        waitDone(100);

        // Board reset in the middle of a soft hold clears the acknowledge.
        applyStimulus(1'b1);
        checkOutput("midsoft_ack", 32'(soft_rst_ack_o), 32'(1));
        #2;
        holdReset(2);
        runTo(34, 1'b0);
        checkOutput("midsoft_done_e34", 32'(rst_done_o), 32'(1));

        // Board reset mid-release, then the power-on timing repeats.
        holdReset(3);
        runTo(20, 1'b0);
        #2;
        holdReset(2);
        runTo(9, 1'b0);
        checkOutput("rerel_e9", 32'(rst_n_o), 32'h0);
        applyStimulus(1'b0);
        checkOutput("rerel_e10", 32'(rst_n_o), 32'h1);
        runTo(34, 1'b0);
        checkOutput("rerel_e34", 32'(rst_n_o), 32'hF);
        checkOutput("rerel_done_e34", 32'(rst_done_o), 32'(1));

        // Request raised during release is only serviced once DONE samples it.
        holdReset(3);
        runTo(19, 1'b0);
        runTo(34, 1'b1);
        checkOutput("early_ack_e34", 32'(soft_rst_ack_o), 32'(0));
        checkOutput("early_done_e34", 32'(rst_done_o), 32'(1));
        applyStimulus(1'b1);
        checkOutput("early_ack_e35", 32'(soft_rst_ack_o), 32'(1));
        checkOutput("early_rst_e35", 32'(rst_n_o), 32'h0);
        applyStimulus(1'b0);
        waitDone(100);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
